// File: rtl/bo_dieu_khien_xung_pkg.sv
// Shared types and helpers for the clock-divider select sequencer.
package bo_dieu_khien_xung_pkg;

  // Divider select width and number of selectable ratios.
  localparam int SEL_W   = 2;
  localparam int NUM_SEL = 4;

  // Sequencer states.
  typedef enum logic [1:0] {
    OFF      = 2'd0,
    RUN      = 2'd1,
    WAIT_LOW = 2'd2,
    APPLY    = 2'd3
  } state_t;

  // Ceiling log2, used to size counters at elaboration time.
  function automatic int clog2(input longint unsigned val);
    int res;
    longint unsigned v;
    res = 0;
    v   = 64'd1;
    while (v < val) begin
      v   = v << 1;
      res = res + 1;
    end
    return res;
  endfunction

  // Next divider selection, wrapping from the last ratio back to the first.
  function automatic logic [SEL_W-1:0] sel_next(input logic [SEL_W-1:0] cur);
    logic [SEL_W-1:0] nxt;
    if (cur == SEL_W'(NUM_SEL - 1)) begin
      nxt = {SEL_W{1'b0}};
    end else begin
      nxt = cur + SEL_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bo_dieu_khien_xung_nut_chong_doi.sv
// Push-button conditioner: 2-flop synchronizer, debounce counter and
// single-cycle pulse on each accepted press.
module nut_chong_doi
  import bo_dieu_khien_xung_pkg::*;
#(
  parameter int DEB_CYC = 1_000_000
) (
  input  logic clki,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic evt
);

  localparam int            CW       = clog2(longint'(DEB_CYC) + 64'd1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic          level_r;
  logic          level_s;
  logic          evt_r;
  logic          evt_s;

  // Bring the raw button into the clki domain.
  always_ff @(posedge clki) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
    end
  end

  // Accept a new level only after it has differed for DEB_CYC straight cycles.
  always_comb begin
    cnt_s   = cnt_r;
    level_s = level_r;
    evt_s   = 1'b0;
    if (sync2_r != level_r) begin
      if (cnt_r == CNT_LAST) begin
        cnt_s   = {CW{1'b0}};
        level_s = sync2_r;
        evt_s   = sync2_r;
      end else begin
        cnt_s   = cnt_r + CW'(1);
      end
    end else begin
      cnt_s = {CW{1'b0}};
    end
  end

  // Debounce state and the registered press pulse.
  always_ff @(posedge clki) begin
    if (rst) begin
      cnt_r   <= {CW{1'b0}};
      level_r <= 1'b0;
      evt_r   <= 1'b0;
    end else begin
      cnt_r   <= cnt_s;
      level_r <= level_s;
      evt_r   <= evt_s;
    end
  end

  assign level = level_r;
  assign evt   = evt_r;

endmodule

// File: rtl/bo_dieu_khien_xung.sv
// Sequencer for the selectable clock divider: steps the select S on a button
// press or after a dwell time, and only switches while the divider output is
// low so the divided clock never sees a runt pulse.
module bo_dieu_khien_xung
  import bo_dieu_khien_xung_pkg::*;
#(
  parameter int DWELL_CYC = 500_000_000,
  parameter int DEB_CYC   = 1_000_000,
  parameter int WAIT_MAX  = 1024,
  parameter int CNT_W     = 29
) (
  input  logic             clki,
  input  logic             rst,
  input  logic             run,
  input  logic             auto_en,
  input  logic             btn_next,
  input  logic             clko_fb,
  output logic [SEL_W-1:0] S,
  output logic             E,
  output logic             sel_busy,
  output logic             sel_done
);

  localparam int               WT_W       = clog2(longint'(WAIT_MAX) + 64'd1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
  localparam logic [WT_W-1:0]  WAIT_LAST  = WT_W'(WAIT_MAX - 1);

  logic             btn_evt_s;
  logic             unused_btn_level_s;
  logic             fb1_r;
  logic             fb2_r;

  state_t           state_r;
  state_t           state_s;
  logic [SEL_W-1:0] s_r;
  logic [SEL_W-1:0] s_s;
  logic [SEL_W-1:0] pend_r;
  logic [SEL_W-1:0] pend_s;
  logic             e_r;
  logic             e_s;
  logic             busy_r;
  logic             busy_s;
  logic             done_r;
  logic             done_s;
  logic [CNT_W-1:0] dwell_r;
  logic [CNT_W-1:0] dwell_s;
  logic [WT_W-1:0]  wait_r;
  logic [WT_W-1:0]  wait_s;
  logic             trig_s;

  nut_chong_doi #(
    .DEB_CYC (DEB_CYC)
  ) u_nut (
    .clki  (clki),
    .rst   (rst),
    .din   (btn_next),
    .level (unused_btn_level_s),
    .evt   (btn_evt_s)
  );

  // Divider output feedback is asynchronous to clki; resynchronize it.
  always_ff @(posedge clki) begin
    if (rst) begin
      fb1_r <= 1'b0;
      fb2_r <= 1'b0;
    end else begin
      fb1_r <= clko_fb;
      fb2_r <= fb1_r;
    end
  end

  // Next-state and next-output logic; run=0 wins over every trigger.
  always_comb begin
    state_s = state_r;
    s_s     = s_r;
    pend_s  = pend_r;
    e_s     = e_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    dwell_s = dwell_r;
    wait_s  = wait_r;
    trig_s  = btn_evt_s | (auto_en & (dwell_r == DWELL_LAST));
    if (!run) begin
      state_s = OFF;
      e_s     = 1'b0;
      busy_s  = 1'b0;
      wait_s  = {WT_W{1'b0}};
    end else begin
      case (state_r)
        OFF: begin
          state_s = RUN;
          e_s     = 1'b1;
          dwell_s = {CNT_W{1'b0}};
          wait_s  = {WT_W{1'b0}};
        end
        RUN: begin
          e_s = 1'b1;
          if (trig_s) begin
            // Button and dwell expiry in the same cycle collapse into one step.
            pend_s  = sel_next(s_r);
            busy_s  = 1'b1;
            wait_s  = {WT_W{1'b0}};
            state_s = WAIT_LOW;
          end else if (auto_en) begin
            dwell_s = dwell_r + CNT_W'(1);
          end else begin
            dwell_s = dwell_r;
          end
        end
        WAIT_LOW: begin
          // Presses arriving here are dropped, not queued.
          wait_s = wait_r + WT_W'(1);
          if (!fb2_r || (wait_r == WAIT_LAST)) begin
            state_s = APPLY;
          end else begin
            state_s = WAIT_LOW;
          end
        end
        APPLY: begin
          s_s     = pend_r;
          done_s  = 1'b1;
          busy_s  = 1'b0;
          dwell_s = {CNT_W{1'b0}};
          wait_s  = {WT_W{1'b0}};
          state_s = RUN;
        end
        default: begin
          state_s = OFF;
          e_s     = 1'b0;
          busy_s  = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clki) begin
    if (rst) begin
      state_r <= OFF;
      s_r     <= {SEL_W{1'b0}};
      pend_r  <= {SEL_W{1'b0}};
      e_r     <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dwell_r <= {CNT_W{1'b0}};
      wait_r  <= {WT_W{1'b0}};
    end else begin
      state_r <= state_s;
      s_r     <= s_s;
      pend_r  <= pend_s;
      e_r     <= e_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      dwell_r <= dwell_s;
      wait_r  <= wait_s;
    end
  end

  assign S        = s_r;
  assign E        = e_r;
  assign sel_busy = busy_r;
  assign sel_done = done_r;

endmodule

// File: tb/tb_bo_dieu_khien_xung.sv
// Scoreboard bench for bo_dieu_khien_xung with short dwell/debounce/wait values.
module tb_bo_dieu_khien_xung;

  localparam int DWELL = 100;
  localparam int DEB   = 8;
  localparam int WMAX  = 16;

  logic       clki     = 1'b0;
  logic       rst      = 1'b1;
  logic       run      = 1'b0;
  logic       auto_en  = 1'b0;
  logic       btn_next = 1'b0;
  logic       clko_fb  = 1'b0;
  logic [1:0] S;
  logic       E;
  logic       sel_busy;
  logic       sel_done;

  int         total = 0;
  int         bad   = 0;
  logic [1:0] exp_q[$];

  int         cyc = 0;
  logic       stuck = 1'b0;
  logic [1:0] div = 2'd0;
  logic       m1 = 1'b0;
  logic       m2 = 1'b0;
  logic [1:0] hist = 2'd0;
  bit         chk_gap = 1'b0;
  bit         have_prev = 1'b0;
  bit         tmo_mode = 1'b0;
  bit         rst_win = 1'b1;
  int         prev_done = 0;
  int         busy_run = 0;
  logic       prev_done_v = 1'b0;
  logic [1:0] prev_s = 2'd0;

  bo_dieu_khien_xung #(
    .DWELL_CYC (DWELL),
    .DEB_CYC   (DEB),
    .WAIT_MAX  (WMAX),
    .CNT_W     (7)
  ) dut (
    .clki     (clki),
    .rst      (rst),
    .run      (run),
    .auto_en  (auto_en),
    .btn_next (btn_next),
    .clko_fb  (clko_fb),
    .S        (S),
    .E        (E),
    .sel_busy (sel_busy),
    .sel_done (sel_done)
  );

  always #5 clki = ~clki;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clki);
    #1;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick(1);
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Divide-by-4 model of the divider output (or stuck high).
  initial forever begin
    @(posedge clki);
    #1;
    div     = div + 2'd1;
    clko_fb = stuck ? 1'b1 : div[1];
  end

  // Cycle count and a reference copy of the feedback synchronizer.
  initial forever begin
    @(posedge clki);
    cyc  = cyc + 1;
    hist = {hist[0], m2};
    m2   = m1;
    m1   = clko_fb;
  end

  // Monitor: pops an expectation on every sel_done pulse.
  initial forever begin
    @(negedge clki);
    if (sel_done) begin
      check("pending_expectation", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        check("done_S", S, exp_q.pop_front());
        check("done_E", E, 1'b1);
        check("done_busy", sel_busy, 1'b0);
        // hist[1] is the synchronized feedback during the last WAIT_LOW cycle.
        if (!stuck) check("fb_low_at_switch", hist[1], 1'b0);
        // Dwell (100) + WAIT_LOW (1..3 with /4 feedback) + APPLY (1).
        if (chk_gap && have_prev)
          check("done_gap_in_range",
                (cyc - prev_done >= DWELL + 2) && (cyc - prev_done <= DWELL + 4), 1'b1);
        // busy spans WAIT_LOW (WAIT_MAX cycles) plus APPLY.
        if (tmo_mode) check("timeout_busy_cycles", busy_run, WMAX + 1);
      end
      check("done_pulse_width", prev_done_v, 1'b0);
      prev_done = cyc;
      have_prev = chk_gap;
    end
    if (!rst_win && (S !== prev_s) && !sel_done) check("S_changed_outside_apply", S, prev_s);
    prev_s      = S;
    prev_done_v = sel_done;
    busy_run    = sel_busy ? busy_run + 1 : 0;
  end

  // Watchdog.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation ran past its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs;
    int k;

    // Reset state.
    tick(3);
    check("rst_S", S, 2'd0);
    check("rst_E", E, 1'b0);
    check("rst_busy", sel_busy, 1'b0);
    check("rst_done", sel_done, 1'b0);

    // Run without auto: E=1, S=0, no sel_done for 500 cycles.
    rst = 1'b0;
    run = 1'b1;
    tick(2);
    rst_win = 1'b0;
    errs = 0;
    for (int i = 0; i < 500; i++) begin
      if (E !== 1'b1 || S !== 2'd0 || sel_done !== 1'b0) errs++;
      tick(1);
    end
    check("run_hold_500", errs, 0);

    // Bouncing button then a solid press: one advance 0->1.
    exp_q.push_back(2'd1);
    for (int i = 0; i < 10; i++) begin
      btn_next = (i % 2 == 0);
      tick(3);
    end
    btn_next = 1'b1;
    tick(20);
    btn_next = 1'b0;
    wait_drain(60, "bounce_advance");
    tick(20);
    check("bounce_single_S", S, 2'd1);

    // A 5-cycle pulse is shorter than the debounce time.
    btn_next = 1'b1;
    tick(5);
    btn_next = 1'b0;
    tick(40);
    check("short_pulse_S", S, 2'd1);

    // Reset mid-run.
    rst_win = 1'b1;
    rst = 1'b1;
    tick(1);
    check("midrst_S", S, 2'd0);
    check("midrst_E", E, 1'b0);
    check("midrst_busy", sel_busy, 1'b0);
    rst = 1'b0;
    tick(1);
    check("midrst_E_back", E, 1'b1);
    tick(2);
    rst_win = 1'b0;

    // Auto cycling 0->1->2->3->0.
    have_prev = 1'b0;
    chk_gap   = 1'b1;
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    auto_en = 1'b1;
    wait_drain(500, "auto_cycle");
    auto_en = 1'b0;
    chk_gap = 1'b0;
    check("auto_wrap_S", S, 2'd0);

    // Feedback stuck high: switch after the wait timeout.
    stuck = 1'b1;
    tick(4);
    tmo_mode = 1'b1;
    exp_q.push_back(2'd1);
    btn_next = 1'b1;
    k = 0;
    while (!sel_busy && k < 40) begin
      tick(1);
      k++;
    end
    check("btn_to_busy_cycles", k, DEB + 3);
    tick(5);
    btn_next = 1'b0;
    wait_drain(40, "timeout_advance");
    tmo_mode = 1'b0;
    stuck    = 1'b0;

    // Button press landing in the dwell-expiry cycle: one step only.
    auto_en = 1'b1;
    exp_q.push_back(2'd2);
    k = 0;
    while (!sel_done && k < 200) begin
      tick(1);
      k++;
    end
    check("sync_done_seen", sel_done, 1'b1);
    exp_q.push_back(2'd3);
    tick(DWELL - DEB - 3);
    btn_next = 1'b1;
    tick(12);
    btn_next = 1'b0;
    wait_drain(40, "coincident_advance");
    auto_en = 1'b0;
    tick(150);
    check("coincident_single_S", S, 2'd3);

    // run=0 while waiting for feedback low.
    stuck = 1'b1;
    tick(4);
    btn_next = 1'b1;
    k = 0;
    while (!sel_busy && k < 40) begin
      tick(1);
      k++;
    end
    check("wait_low_entered", sel_busy, 1'b1);
    btn_next = 1'b0;
    tick(3);
    run = 1'b0;
    tick(1);
    check("runoff_E", E, 1'b0);
    check("runoff_S", S, 2'd3);
    check("runoff_busy", sel_busy, 1'b0);
    tick(40);
    check("runoff_S_held", S, 2'd3);
    stuck = 1'b0;

    // Re-asserting run restarts the dwell count from zero.
    auto_en = 1'b1;
    run = 1'b1;
    tick(40);
    run = 1'b0;
    tick(10);
    exp_q.push_back(2'd0);
    run = 1'b1;
    k = 0;
    while (!sel_busy && k < 300) begin
      tick(1);
      k++;
    end
    check("dwell_restart_cycles", k, DWELL + 1);
    wait_drain(40, "restart_advance");
    auto_en = 1'b0;
    tick(5);
    check("final_S", S, 2'd0);
    check("queue_empty_end", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
